i2c_slave: RTL and testbench

Write-only I2C target that receives the three-byte transactions produced by the codec configuration master: device address, then two payload bytes. It watches `scl`/`sda` with an oversampling `inClock`, acknowledges only its own address, and drives `sda` open-drain for ACK. It presents each completed 16-bit payload with a one-cycle strobe. It serves as the codec-side model in the audio bench and as a configuration receiver in on-board loopback.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_slave_if.sv | 38 +++
 rtl/i2c_line_filter.sv | 49 ++++
 rtl/i2c_slave.sv | 171 +++++++++++++++++
 tb/tb_i2c_slave.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the write-only I2C configuration target.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  localparam logic [6:0] CODEC_ADDR = 7'h1A;
  localparam int         PAYLOAD_W  = 16;

endpackage

// File: rtl/i2c_slave_if.sv
// I2C bus plus received-payload signals of the configuration target.
// sda is the open-drain wired-AND of both sides; a released line reads high.
interface i2c_slave_if;
  import i2c_pkg::*;

  logic                 scl;
  logic                 sda_master_low;
  logic                 sda_oe;
  wire                  sda;
  logic [PAYLOAD_W-1:0] outData;
  logic                 outValid;
  logic                 busy;
  logic                 error;

  // Either side pulling low wins; nobody ever drives the line high.
  assign sda = ~(sda_oe | sda_master_low);

  modport slave (
    input  scl,
    input  sda,
    output sda_oe,
    output outData,
    output outValid,
    output busy,
    output error
  );

  modport master (
    output scl,
    output sda_master_low,
    input  sda,
    input  outData,
    input  outValid,
    input  busy,
    input  error
  );

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer for one bus line, followed by an optional debounce
// compiled in with I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic inClock,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic [1:0] sync;

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous,
  // so rst is just another input sampled on the clock edge.
  always_ff @(posedge inClock) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], raw};
  end

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("i2c_line_filter: FILTER_LEN must be at least 1");
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [CW-1:0] run;

  // Count consecutive samples that disagree with the accepted level; flip
  // only once FILTER_LEN of them have been seen in a row.
  always_ff @(posedge inClock) begin
    if (rst) begin
      level <= 1'b1;
      run   <= '0;
    end else if (sync[1] == level) begin
      run <= '0;
    end else if (run == CW'(FILTER_LEN - 1)) begin
      level <= sync[1];
      run   <= '0;
    end else begin
      run <= run + CW'(1);
    end
  end
`else
  assign level = sync[1];
`endif

endmodule

// File: rtl/i2c_slave.sv
// Write-only I2C target: address byte plus two payload bytes, open-drain ACK.
// Define I2C_SLAVE_GLITCH_FILTER_EN to debounce scl/sda by FILTER_LEN samples.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = CODEC_ADDR,
  parameter int         FILTER_LEN = 3
) (
  input logic         inClock,
  input logic         rst,
  i2c_slave_if.slave  bus
);

  logic scl_f, sda_f, scl_q, sda_q;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .inClock (inClock),
    .rst     (rst),
    .raw     (bus.scl),
    .level   (scl_f)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .inClock (inClock),
    .rst     (rst),
    .raw     (bus.sda),
    .level   (sda_f)
  );

  always_ff @(posedge inClock) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c;

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;

  state_t               state, state_n;
  logic [2:0]           bit_cnt, bit_cnt_n;
  logic                 byte_full, byte_full_n;
  logic [7:0]           shreg, shreg_n;
  logic [7:0]           byte1, byte1_n;
  logic [1:0]           byte_cnt, byte_cnt_n;
  logic [PAYLOAD_W-1:0] data_q, data_n;
  logic                 valid_q, valid_n;
  logic                 err_q, err_n;
  logic                 ack_q, ack_n;

  always_ff @(posedge inClock) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      byte_full <= 1'b0;
      shreg     <= '0;
      byte1     <= '0;
      byte_cnt  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      byte_full <= byte_full_n;
      shreg     <= shreg_n;
      byte1     <= byte1_n;
      byte_cnt  <= byte_cnt_n;
      data_q    <= data_n;
      valid_q   <= valid_n;
      err_q     <= err_n;
      ack_q     <= ack_n;
    end
  end

  always_comb begin
    // NOTE: every next-value gets a default up front so no path infers a latch.
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    byte_full_n = byte_full;
    shreg_n     = shreg;
    byte1_n     = byte1;
    byte_cnt_n  = byte_cnt;
    data_n      = data_q;
    valid_n     = 1'b0;
    err_n       = err_q;
    ack_n       = ack_q;

    if (start_c) begin
      state_n     = ADDR;
      bit_cnt_n   = '0;
      byte_full_n = 1'b0;
      byte_cnt_n  = '0;
      ack_n       = 1'b0;
      err_n       = 1'b0;
    end else if (stop_c) begin
      state_n     = IDLE;
      bit_cnt_n   = '0;
      byte_full_n = 1'b0;
      byte_cnt_n  = '0;
      ack_n       = 1'b0;
    end else begin
      case (state)
        ADDR, DATA: begin
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_f};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_full_n = 1'b1;
          end else if (scl_fall && byte_full) begin
            // The falling edge after bit 8 is where the ACK slot opens.
            byte_full_n = 1'b0;
            if (state == ADDR) begin
              if (shreg[7:1] != DEV_ADDR) begin
                state_n = IGNORE;
              end else if (shreg[0] == I2C_READ) begin
                state_n = IGNORE;
                err_n   = 1'b1;
              end else begin
                state_n = ADDR_ACK;
                ack_n   = 1'b1;
              end
            end else begin
              case (byte_cnt)
                2'd0: begin
                  byte1_n    = shreg;
                  byte_cnt_n = 2'd1;
                  state_n    = DATA_ACK;
                  ack_n      = 1'b1;
                end
                2'd1: begin
                  data_n     = {byte1, shreg};
                  valid_n    = 1'b1;
                  byte_cnt_n = 2'd2;
                  state_n    = DATA_ACK;
                  ack_n      = 1'b1;
                end
                default: begin
                  err_n   = 1'b1;
                  state_n = IGNORE;
                end
              endcase
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            state_n   = DATA;
            ack_n     = 1'b0;
            bit_cnt_n = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe   = ack_q;
  assign bus.outData  = data_q;
  assign bus.outValid = valid_q;
  assign bus.error    = err_q;
  assign bus.busy     = state inside {ADDR_ACK, DATA, DATA_ACK};

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, a vector table, hand-written
// corner sequences and randomized transactions scored against a transaction model.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam logic [6:0] DEV = 7'h1A;
  localparam int H = 20;       // scl half period in inClock cycles
  localparam int Q = H / 2;

  logic inClock = 1'b0;
  logic rst     = 1'b1;

  i2c_slave_if bus ();

  i2c_slave #(.DEV_ADDR(DEV), .FILTER_LEN(3)) dut (
    .inClock (inClock),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 inClock = ~inClock;

  int n_checks = 0;
  int n_errors = 0;

  int   valid_total = 0;
  int   double_cnt  = 0;
  logic valid_prev  = 1'b0;

  always @(negedge inClock) begin
    if (bus.outValid) valid_total++;
    if (bus.outValid && valid_prev) double_cnt++;
    valid_prev = bus.outValid;
  end

  typedef struct {
    logic [3:0][7:0] b;
    int              n;
    logic [3:0]      exp_ack;
    int              exp_valid;
    logic [15:0]     exp_data;
    logic            exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge inClock);
  endtask

  task automatic set_sda(input logic lvl);
    bus.sda_master_low = ~lvl;
  endtask

  task automatic do_start();
    set_sda(1'b1); cyc(Q);
    bus.scl = 1'b1; cyc(H);
    set_sda(1'b0); cyc(H);
    bus.scl = 1'b0; cyc(Q);
  endtask

  task automatic do_stop();
    set_sda(1'b0); cyc(Q);
    bus.scl = 1'b1; cyc(H);
    set_sda(1'b1); cyc(H);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      set_sda(b[i]); cyc(Q);
      bus.scl = 1'b1; cyc(H);
      bus.scl = 1'b0; cyc(Q);
    end
  endtask

  task automatic ack_phase(output logic acked, output logic busy_s);
    set_sda(1'b1); cyc(Q);
    bus.scl = 1'b1; cyc(Q);
    acked  = (bus.sda == 1'b0);
    busy_s = bus.busy;
    cyc(Q);
    bus.scl = 1'b0; cyc(Q);
  endtask

  task automatic run_txn(input logic [3:0][7:0] b, input int n,
                         output logic [3:0] ack_mask, output logic busy_addr);
    logic a, bz;
    ack_mask  = '0;
    busy_addr = 1'b0;
    do_start();
    for (int i = 0; i < n; i++) begin
      send_bits(b[i]);
      ack_phase(a, bz);
      ack_mask[i] = a;
      if (i == 0) busy_addr = bz;
    end
    do_stop();
  endtask

  // Transaction-level reference: what one START..STOP write should yield.
  function automatic void model_txn(input logic [3:0][7:0] b, input int n,
                                    inout logic [15:0] data, output logic [3:0] ack,
                                    output int nvalid, output logic err);
    logic for_us;
    for_us = (b[0][7:1] == DEV);
    ack    = '0;
    nvalid = 0;
    err    = 1'b0;
    if (for_us && b[0][0]) begin
      err = 1'b1;
    end else if (for_us) begin
      ack[0] = 1'b1;
      for (int i = 1; i < n; i++) begin
        if (i <= 2) ack[i] = 1'b1;
        else        err    = 1'b1;
      end
      if (n >= 3) begin
        data   = {b[1], b[2]};
        nvalid = 1;
      end
    end
  endfunction

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, input int n,
                              input logic [3:0] ack, input int nv,
                              input logic [15:0] d, input logic e);
    vec_t v;
    v.b         = {b3, b2, b1, b0};
    v.n         = n;
    v.exp_ack   = ack;
    v.exp_valid = nv;
    v.exp_data  = d;
    v.exp_err   = e;
    return v;
  endfunction

  task automatic apply_and_check(input string tag, input logic [3:0][7:0] b, input int n,
                                 input logic [3:0] exp_ack, input int exp_valid,
                                 input logic [15:0] exp_data, input logic exp_err);
    logic [3:0] ack;
    logic       busy_addr;
    int         v0;
    v0 = valid_total;
    run_txn(b, n, ack, busy_addr);
    cyc(4);
    check({tag, " ack"},        32'(ack),                    32'(exp_ack));
    check({tag, " busy_addr"},  32'(busy_addr),              32'(exp_ack[0]));
    check({tag, " valid_cnt"},  32'(valid_total - v0),       32'(exp_valid));
    check({tag, " outData"},    32'(bus.outData),            32'(exp_data));
    check({tag, " error"},      32'(bus.error),              32'(exp_err));
    check({tag, " idle"},       32'({bus.busy, bus.sda}),    32'(2'b01));
  endtask

  initial begin
    logic        a, bz;
    logic [15:0] m_data;
    logic [3:0]  m_ack;
    int          m_nv;
    logic        m_err;
    logic [3:0][7:0] rb;
    int          rn, v0;
    logic [6:0]  ra;

    bus.scl = 1'b1;
    set_sda(1'b1);

    vecs[0] = mk(8'h34, 8'h1E, 8'h00, 8'h00, 3, 4'b0111, 1, 16'h1E00, 1'b0);
    vecs[1] = mk(8'h36, 8'h55, 8'h00, 8'h00, 2, 4'b0000, 0, 16'h1E00, 1'b0);
    vecs[2] = mk(8'h35, 8'h77, 8'h00, 8'h00, 2, 4'b0000, 0, 16'h1E00, 1'b1);
    vecs[3] = mk(8'h34, 8'h12, 8'h00, 8'h00, 2, 4'b0011, 0, 16'h1E00, 1'b0);
    vecs[4] = mk(8'h34, 8'h01, 8'h02, 8'h03, 4, 4'b0111, 1, 16'h0102, 1'b1);

    cyc(5);
    check("reset outputs", 32'({bus.outData, bus.outValid, bus.busy, bus.error, bus.sda}),
          32'({16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}));
    rst = 1'b0;
    cyc(5);

    for (int i = 0; i < 5; i++)
      apply_and_check($sformatf("vec%0d", i), vecs[i].b, vecs[i].n, vecs[i].exp_ack,
                      vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_err);

    // Read request sets error; the next (repeated) START clears it, then a
    // write interrupted by another repeated START still delivers one payload.
    v0 = valid_total;
    do_start();
    send_bits(8'h35); ack_phase(a, bz);
    check("read nack",       32'(a),         32'(0));
    check("read error set",  32'(bus.error), 32'(1));
    do_start();
    check("start clears error", 32'(bus.error), 32'(0));
    send_bits(8'h34); ack_phase(a, bz); check("rs addr1 ack", 32'(a), 32'(1));
    send_bits(8'hAA); ack_phase(a, bz); check("rs byteAA ack", 32'(a), 32'(1));
    do_start();
    send_bits(8'h34); ack_phase(a, bz); check("rs addr2 ack", 32'(a), 32'(1));
    send_bits(8'h0C); ack_phase(a, bz); check("rs byte0C ack", 32'(a), 32'(1));
    send_bits(8'h9F); ack_phase(a, bz); check("rs byte9F ack", 32'(a), 32'(1));
    do_stop(); cyc(4);
    check("rs valid_cnt", 32'(valid_total - v0), 32'(1));
    check("rs outData",   32'(bus.outData),      32'(16'h0C9F));

    m_data = 16'h0C9F;
    for (int t = 0; t < 30; t++) begin
      rn = int'($urandom_range(1, 4));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: ra = DEV;
        5, 6:          ra = DEV;
        default: begin
          ra = 7'($urandom);
          if (ra == DEV) ra = ra ^ 7'h01;
        end
      endcase
      rb = 32'($urandom);
      rb[0] = {ra, ($urandom_range(0, 9) >= 7) ? I2C_READ : I2C_WRITE};
      model_txn(rb, rn, m_data, m_ack, m_nv, m_err);
      apply_and_check($sformatf("rand%0d", t), rb, rn, m_ack, m_nv, m_data, m_err);
    end

    // Reset while the ACK is being driven releases sda on that very edge.
    do_start();
    send_bits(8'h34); ack_phase(a, bz);
    send_bits(8'h01);
    set_sda(1'b1); cyc(Q);
    bus.scl = 1'b1; cyc(Q);
    check("ack driven before rst", 32'(bus.sda), 32'(0));
    rst = 1'b1;
    @(posedge inClock); #1;
    check("rst releases sda", 32'(bus.sda), 32'(1));
    @(negedge inClock);
    rst = 1'b0;
    cyc(Q);
    bus.scl = 1'b0; cyc(Q);
    do_stop(); cyc(4);
    check("post rst state", 32'({bus.outData, bus.busy, bus.error, bus.sda}),
          32'({16'h0000, 1'b0, 1'b0, 1'b1}));

    check("no double strobe", 32'(double_cnt), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
